// File: rtl/wave_sequencer.sv
// wave_sequencer
//   Phase-accumulator controller for a 512-sample quarter-wave-symmetric sine
//   datapath. Produces the sample index, quarter-ROM address and
//   mirror/invert controls at a programmable tick rate and frequency, with
//   start / graceful stop and glitch-free retuning at cycle boundaries.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start, stop       level-sampled run control (stop drains to cycle end)
//   cfg_valid/ready   config handshake; cfg_step = phase increment per tick,
//                     cfg_div = tick period minus 1 in clk cycles
//   busy              state is not IDLE
//   sample_valid      one-cycle pulse with each new sample_idx
//   sample_idx        9-bit position within the waveform cycle
//   rom_addr          7-bit quarter-ROM address (combinational)
//   mirror, invert    sample_idx[7], sample_idx[8] (combinational)
//   cycle_done        one-cycle pulse on phase wrap
module wave_sequencer #(
  parameter int unsigned PHASE_W = 16,
  parameter int unsigned DIV_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_step,
  input  logic [DIV_W-1:0]   cfg_div,
  output logic               busy,
  output logic               sample_valid,
  output logic [8:0]         sample_idx,
  output logic [6:0]         rom_addr,
  output logic               mirror,
  output logic               invert,
  output logic               cycle_done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  // One sample index per tick.
  localparam logic [PHASE_W-1:0] STEP_RST = {{8{1'b0}}, 1'b1, {(PHASE_W-9){1'b0}}};

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [PHASE_W-1:0] step_q, step_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [PHASE_W-1:0] sh_step_q, sh_step_d;
  logic [DIV_W-1:0]   sh_div_q, sh_div_d;
  logic               pending_q, pending_d;
  logic               sv_q, sv_d;
  logic               cd_q, cd_d;
  logic [8:0]         idx_q, idx_d;

  logic [PHASE_W:0]   sum;
  logic               tick;
  logic               carry;

  assign sum   = {1'b0, phase_q} + {1'b0, step_q};
  assign tick  = (state_q != IDLE) && (cnt_q == div_q);
  assign carry = tick && sum[PHASE_W];

  assign cfg_ready    = (state_q == IDLE) || !pending_q;
  assign busy         = (state_q != IDLE);
  assign sample_valid = sv_q;
  assign sample_idx   = idx_q;
  assign cycle_done   = cd_q;
  assign mirror       = idx_q[7];
  assign invert       = idx_q[8];
  assign rom_addr     = idx_q[7] ? ~idx_q[6:0] : idx_q[6:0];

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    div_d     = div_q;
    sh_step_d = sh_step_q;
    sh_div_d  = sh_div_q;
    pending_d = pending_q;
    sv_d      = 1'b0;
    cd_d      = 1'b0;
    idx_d     = idx_q;

    case (state_q)
      IDLE: begin
        phase_d = '0;
        idx_d   = '0;
        cnt_d   = '0;
        // A config accepted on the terminating DRAIN tick lands here as
        // pending; commit it now since there is no running cycle to protect.
        if (pending_q) begin
          step_d    = sh_step_q;
          div_d     = sh_div_q;
          pending_d = 1'b0;
        end
        if (cfg_valid) begin
          step_d = cfg_step;
          div_d  = cfg_div;
        end
        if (start && !stop) begin
          state_d = RUN;
        end
      end

      RUN, DRAIN: begin
        if (tick) begin
          cnt_d   = '0;
          phase_d = sum[PHASE_W-1:0];
          idx_d   = sum[PHASE_W-1 -: 9];
          sv_d    = 1'b1;
          cd_d    = sum[PHASE_W];
          if (carry && pending_q) begin
            step_d    = sh_step_q;
            div_d     = sh_div_q;
            pending_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end

        // Acceptance is judged on the registered pending flag, so an offer
        // landing on a carry tick re-arms pending for the next wrap.
        if (cfg_valid && !pending_q) begin
          sh_step_d = cfg_step;
          sh_div_d  = cfg_div;
          pending_d = 1'b1;
        end

        if (state_q == RUN) begin
          if (stop) begin
            if (step_q == '0) begin
              // Phase never wraps with a zero step: leave without a tick.
              state_d = IDLE;
              phase_d = '0;
              idx_d   = '0;
              cnt_d   = '0;
              sv_d    = 1'b0;
              cd_d    = 1'b0;
            end else begin
              state_d = DRAIN;
            end
          end
        end else begin
          if (step_q == '0) begin
            state_d = IDLE;
            phase_d = '0;
            idx_d   = '0;
            cnt_d   = '0;
            sv_d    = 1'b0;
            cd_d    = 1'b0;
          end else if (carry) begin
            state_d = IDLE;
            phase_d = '0;
            idx_d   = '0;
            cnt_d   = '0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      cnt_q     <= '0;
      step_q    <= STEP_RST;
      div_q     <= '0;
      sh_step_q <= '0;
      sh_div_q  <= '0;
      pending_q <= 1'b0;
      sv_q      <= 1'b0;
      cd_q      <= 1'b0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      div_q     <= div_d;
      sh_step_q <= sh_step_d;
      sh_div_q  <= sh_div_d;
      pending_q <= pending_d;
      sv_q      <= sv_d;
      cd_q      <= cd_d;
      idx_q     <= idx_d;
    end
  end

endmodule

// File: tb/tb_wave_sequencer.sv
module tb_wave_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_step;
  logic [15:0] cfg_div;
  logic        busy;
  logic        sample_valid;
  logic [8:0]  sample_idx;
  logic [6:0]  rom_addr;
  logic        mirror;
  logic        invert;
  logic        cycle_done;

  wave_sequencer #(.PHASE_W(16), .DIV_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_step     (cfg_step),
    .cfg_div      (cfg_div),
    .busy         (busy),
    .sample_valid (sample_valid),
    .sample_idx   (sample_idx),
    .rom_addr     (rom_addr),
    .mirror       (mirror),
    .invert       (invert),
    .cycle_done   (cycle_done)
  );

  typedef struct {
    int idx;
    int cd;
    int gap;   // expected cycles since previous sample, 0 = unchecked
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting, expected event (t=%0t)", name, $time);
  endtask

  task automatic push(input int idx, input int cd, input int gap);
    exp_t e;
    e.idx = idx;
    e.cd  = cd;
    e.gap = gap;
    sb.push_back(e);
  endtask

  // One full waveform cycle at index stride s: s, 2s, ..., 0 (with wrap).
  task automatic push_cycle(input int s, input int gap0, input int gap);
    int g;
    g = gap0;
    for (int v = s; v < 512; v += s) begin
      push(v, 0, g);
      g = gap;
    end
    push(0, 1, gap);
  endtask

  // Scoreboard monitor: pops one expectation per presented sample.
  initial begin
    exp_t e;
    int   since;
    int   exp_rom;
    since = 0;
    forever begin
      @(negedge clk);
      since++;
      if (rst_n && sample_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_sample: got idx %0d, expected no sample (t=%0t)",
                   sample_idx, $time);
        end else begin
          e = sb.pop_front();
          exp_rom = ((e.idx / 128) % 2 == 1) ? 127 - (e.idx % 128) : e.idx % 128;
          chk("sample_idx", int'(sample_idx), e.idx);
          chk("cycle_done", int'(cycle_done), e.cd);
          chk("rom_addr",   int'(rom_addr),   exp_rom);
          chk("mirror",     int'(mirror),     (e.idx / 128) % 2);
          chk("invert",     int'(invert),     e.idx / 256);
          if (e.gap != 0) chk("sample_gap", since, e.gap);
        end
        since = 0;
      end
    end
  end

  task automatic wait_idx(input int target);
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (sample_valid && int'(sample_idx) == target) return;
    end
    timeout_fail($sformatf("wait_idx_%0d", target));
  endtask

  task automatic wait_cd();
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (sample_valid && cycle_done) return;
    end
    timeout_fail("wait_cycle_done");
  endtask

  task automatic wait_sv();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sample_valid) return;
    end
    timeout_fail("wait_sample_valid");
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 6000 && sb.size() != 0; i++) @(negedge clk);
    chk(name, sb.size(), 0);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic stop_pulse();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic cfg_idle(input logic [15:0] s, input logic [15:0] d);
    cfg_valid = 1'b1;
    cfg_step  = s;
    cfg_div   = d;
    chk("cfg_ready_idle", int'(cfg_ready), 1);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_valid = 1'b0; cfg_step = '0; cfg_div = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy",         int'(busy),         0);
    chk("rst_sample_valid", int'(sample_valid), 0);
    chk("rst_cycle_done",   int'(cycle_done),   0);
    chk("rst_sample_idx",   int'(sample_idx),   0);
    chk("rst_cfg_ready",    int'(cfg_ready),    1);

    // Default config, div=0: two full cycles, stop at idx 300 of the second.
    push_cycle(1, 0, 1);
    push_cycle(1, 1, 1);
    start_pulse();
    @(negedge clk);
    chk("first_sample_latency", int'(sample_valid), 1);
    wait_cd();
    wait_idx(300);
    stop_pulse();
    wait_idx(511);
    chk("busy_in_drain", int'(busy), 1);
    wait_cd();
    chk("busy_after_drain", int'(busy), 0);
    wait_drain("sb_empty_default");
    repeat (20) @(negedge clk);
    chk("idle_no_sample", int'(sample_valid), 0);

    // step=0x0100, div=3: stride 2, one sample every 4 cycles.
    cfg_idle(16'h0100, 16'd3);
    push_cycle(2, 0, 4);
    push_cycle(2, 4, 4);
    start_pulse();
    wait_cd();
    wait_idx(100);
    stop_pulse();
    wait_drain("sb_empty_div3");
    repeat (2) @(negedge clk);
    chk("busy_after_div3", int'(busy), 0);

    // Retune in RUN: step 0x0200 offered at idx 50, applied after the wrap.
    cfg_idle(16'h0080, 16'd0);
    push_cycle(1, 0, 1);
    push_cycle(4, 1, 1);
    start_pulse();
    wait_idx(50);
    cfg_valid = 1'b1;
    cfg_step  = 16'h0200;
    cfg_div   = 16'd0;
    chk("cfg_ready_run", int'(cfg_ready), 1);
    @(negedge clk);
    chk("cfg_ready_pending", int'(cfg_ready), 0);
    cfg_step = 16'h0040;   // second offer, must be stalled
    repeat (5) @(negedge clk);
    chk("cfg_ready_stalled", int'(cfg_ready), 0);
    cfg_valid = 1'b0;
    wait_cd();
    chk("cfg_ready_after_wrap", int'(cfg_ready), 1);
    wait_idx(200);
    stop_pulse();
    wait_drain("sb_empty_retune");

    // step=0 (div=1): stop goes straight back to IDLE.
    repeat (2) @(negedge clk);
    cfg_idle(16'h0000, 16'd1);
    push(0, 0, 0);
    push(0, 0, 2);
    start_pulse();
    wait_sv();
    wait_sv();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("step0_stop_busy", int'(busy), 0);
    chk("step0_stop_idx",  int'(sample_idx), 0);
    repeat (4) @(negedge clk);
    chk("sb_empty_step0", sb.size(), 0);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    chk("start_stop_stays_idle", int'(busy), 0);
    repeat (4) @(negedge clk);
    chk("start_stop_still_idle", int'(busy), 0);

    // Reset in the middle of DRAIN with a config pending.
    cfg_idle(16'h0100, 16'd0);
    for (int v = 2; v <= 400; v += 2) push(v, 0, (v == 2) ? 0 : 1);
    start_pulse();
    wait_idx(300);
    stop_pulse();
    cfg_valid = 1'b1;
    cfg_step  = 16'h0040;
    cfg_div   = 16'd0;
    chk("cfg_ready_drain", int'(cfg_ready), 1);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("cfg_ready_drain_pending", int'(cfg_ready), 0);
    wait_idx(400);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy",         int'(busy),         0);
    chk("async_rst_sample_valid", int'(sample_valid), 0);
    chk("async_rst_cycle_done",   int'(cycle_done),   0);
    chk("async_rst_sample_idx",   int'(sample_idx),   0);
    chk("async_rst_rom_addr",     int'(rom_addr),     0);
    chk("async_rst_invert",       int'(invert),       0);
    chk("async_rst_cfg_ready",    int'(cfg_ready),    1);
    @(negedge clk);
    rst_n = 1'b1;
    chk("sb_empty_at_reset", sb.size(), 0);
    @(negedge clk);

    // Restored default config: stride 1, every cycle, no pending retune.
    push_cycle(1, 0, 1);
    start_pulse();
    chk("pending_cleared_by_reset", int'(cfg_ready), 1);
    wait_idx(5);
    stop_pulse();
    wait_drain("sb_empty_after_reset");
    repeat (2) @(negedge clk);
    chk("busy_final", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wave_sequencer.md
Name: wave_sequencer

Overview:
- Phase-accumulator controller that sequences the 512-sample quarter-wave-symmetric sine datapath feeding the 10-bit DAC.
- Produces the sample index, the quarter-ROM address, and mirror/invert controls at a programmable tick rate and frequency.
- Provides start/graceful-stop control and glitch-free retuning through a valid/ready config port; updates are applied only at a waveform cycle boundary.

Parameters:
- PHASE_W, 16, phase accumulator width; sample_idx = phase[PHASE_W-1:PHASE_W-9].
- DIV_W, 16, width of the sample-rate divider.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- start  in  1  level-sampled start request.
- stop  in  1  level-sampled stop request; stop is graceful.
- cfg_valid  in  1  new config offered.
- cfg_ready  out  1  config can be accepted this cycle.
- cfg_step  in  PHASE_W  phase increment per tick.
- cfg_div  in  DIV_W  tick period minus 1, in clk cycles.
- busy  out  1  state is not IDLE.
- sample_valid  out  1  one-cycle pulse: new sample_idx presented.
- sample_idx  out  9  current sample position in the cycle.
- rom_addr  out  7  quarter-ROM address.
- mirror  out  1  sample_idx[7].
- invert  out  1  sample_idx[8]; downstream computes 1024 - rom.
- cycle_done  out  1  one-cycle pulse on phase wrap.

Behaviour:
- Interface: one clock, clk; rst_n is asynchronous, active-low. All outputs are registered except cfg_ready, rom_addr, mirror and invert, which are combinational from state and registers.
- Reset values:
  - state=IDLE; phase=0; cnt=0; pending=0; busy=0; sample_valid=0; cycle_done=0; sample_idx=0.
  - Reset during any state aborts immediately to these values; no drain.
- Reset config: step_reg=1<<(PHASE_W-9), i.e. one index per tick; div_reg=0.
- Index mapping:
  - rom_addr = mirror ? ~sample_idx[6:0] : sample_idx[6:0]. Addresses 0..127; mirrored quadrant gives 127-(idx-128).
  - mirror = sample_idx[7]; invert = sample_idx[8].
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: start && !stop -> RUN with cnt<=0. start && stop together -> stay in IDLE. phase held at 0, so the output sits at midscale.
  - RUN: stop -> DRAIN; if step_reg==0, stop -> IDLE directly. start is ignored.
  - DRAIN: on the wrapping tick -> IDLE with phase<=0 and sample_idx<=0. start/stop ignored. With step_reg==0 -> IDLE next cycle.
- Tick generation (RUN or DRAIN):
  - If cnt==div_reg: tick, cnt<=0; else cnt<=cnt+1. Tick period is div_reg+1 cycles.
- On each tick:
  - {carry,phase} <= phase+step_reg (PHASE_W+1-bit add; phase wraps modulo 2^PHASE_W).
  - sample_idx is updated from the new phase; sample_valid<=1 for that one cycle.
  - cycle_done<=carry.
- Latency: with start sampled at edge 0 and div_reg=0, the first sample_valid is high after edge 1 with sample_idx=1 (default step).
- Config handshake:
  - In IDLE: cfg_ready=1; cfg_valid loads step_reg/div_reg directly, effective on the next start.
  - In RUN/DRAIN: cfg_ready = !pending. An accepted config goes into a shadow register and sets pending.
  - On the next carry tick the shadow is copied to step_reg/div_reg, pending clears, and cnt is already 0 from the tick. The new step applies from the following tick.
  - Config accepted in the same cycle as a carry tick stays pending until the next carry.
  - In DRAIN, a pending config is applied on the terminating carry.
  - cfg_valid while cfg_ready=0: no effect; the offer must be held.

Test Plan:
- Reset, start, default config, div=0 → sample_idx 1,2,...,511,0 on consecutive cycles with sample_valid constant 1. cycle_done high only with idx 0 (512th tick). rom_addr=127 at idx 128, rom_addr=0 at idx 255. invert=1 for idx 256..511.
- IDLE config step=0x0100, div=3, then start → sample_valid every 4th cycle; idx steps by 2; 256 ticks per cycle_done.
- While in RUN, offer step=0x0200 at idx 50 → cfg_ready drops until wrap; idx runs 50..511,0 at step 1, then 4,8,...; a second cfg_valid is stalled while pending.
- stop at idx 300 → busy stays 1 through idx 511; the terminating tick gives idx 0 with cycle_done; then IDLE; further ticks produce no sample_valid.
- step=0 in RUN, then stop → IDLE within 2 cycles, sample_idx=0. start+stop together in IDLE → stays IDLE.
- Assert rst_n low mid-DRAIN at idx 400 → all outputs reset within the same cycle (async); pending cleared; step_reg/div_reg back to 0x0080/0.
